// File: rtl/si_tag_packetizer_if.sv
// Tag-in / packet-out stream bundle for si_tag_packetizer.
// The slave modport is the packetizer's view; the master modport is the
// view of whatever feeds tags in and drains packets out.
interface si_tag_packetizer_if #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8
);
    // Tag input stream
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [31:0]           s_axis_tdata;
    logic                  s_axis_tlast;
    logic [31:0]           s_axis_tuser;

    // Packet output stream
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tlast;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/si_tag_packetizer.sv
// si_tag_packetizer: packs 32-bit time tags eight per 256-bit beat behind a
// header beat carrying a sequence number and the packet's rollover time.
// Packets close on MAX_BEATS full beats, an input tlast, a rollover change,
// or an idle timeout.
// Optional macro SI_PACKETIZER_STATS_EN adds packet_count / tag_count outputs.
module si_tag_packetizer #(
    parameter int DATA_WIDTH     = 256,
    parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    si_tag_packetizer_if.slave  bus
`ifdef SI_PACKETIZER_STATS_EN
    ,
    output logic [31:0]         packet_count,
    output logic [31:0]         tag_count
`endif
);

    if (DATA_WIDTH != 256) begin : g_bad_width
        $error("si_tag_packetizer: only DATA_WIDTH=256 is supported");
    end
    if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_keep
        $error("si_tag_packetizer: KEEP_WIDTH must be DATA_WIDTH/8");
    end
    if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_beats
        $error("si_tag_packetizer: MAX_BEATS must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("si_tag_packetizer: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [31:0]           seq_q, seq_d;
    logic [31:0]           roll_q, roll_d;
    logic [DATA_WIDTH-1:0] lanes_q, lanes_d;
    logic [3:0]            lane_cnt_q, lane_cnt_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [15:0]           timer_q, timer_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;

    logic                  s_ready;
    logic                  take;
    logic                  out_free;
    logic                  pend_full;
    logic                  move_full;
    logic                  move_last;
    logic                  mismatch;
    logic                  timeout;
    logic [2:0]            lane_idx;

    function automatic logic [DATA_WIDTH-1:0] header_beat(input logic [31:0] seq,
                                                          input logic [31:0] roll);
        header_beat          = '0;
        header_beat[31:0]    = seq;
        header_beat[63:32]   = roll;
        header_beat[79:64]   = 16'h5349;
        header_beat[87:80]   = 8'h01;
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] lane_keep(input logic [3:0] cnt);
        lane_keep = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < cnt) lane_keep[4*i +: 4] = 4'hF;
        end
    endfunction

    // Next-state, lane packing and output-register loading
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        roll_d      = roll_q;
        lanes_d     = lanes_q;
        lane_cnt_d  = lane_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        timer_d     = timer_q;
        out_valid_d = out_valid_q && !bus.m_axis_tready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        s_ready     = 1'b0;
        take        = 1'b0;
        lane_idx    = lane_cnt_q[2:0];

        // Output register can take a new beat when empty or being drained.
        out_free  = !out_valid_q || bus.m_axis_tready;
        pend_full = (lane_cnt_q == 4'd8);
        move_full = (state_q == FILL) && pend_full && out_free;
        move_last = move_full && (beat_cnt_q == 8'(MAX_BEATS - 1));
        mismatch  = bus.s_axis_tvalid && (bus.s_axis_tuser != roll_q);
        timeout   = 1'b0;

        case (state_q)
            IDLE: begin
                s_ready = out_free;
                take    = s_ready && bus.s_axis_tvalid;
                if (take) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = header_beat(seq_q, bus.s_axis_tuser);
                    out_keep_d    = '1;
                    out_last_d    = 1'b0;
                    seq_d         = seq_q + 32'd1;
                    roll_d        = bus.s_axis_tuser;
                    lanes_d       = '0;
                    lanes_d[31:0] = bus.s_axis_tdata;
                    lane_cnt_d    = 4'd1;
                    beat_cnt_d    = 8'd0;
                    timer_d       = 16'd0;
                    state_d       = bus.s_axis_tlast ? FLUSH : FILL;
                end
            end

            FILL: begin
                // A full beat blocks input until it can leave; the packet's
                // closing beat also blocks, so the next tag opens a new header.
                s_ready = (!pend_full || (move_full && !move_last)) && !mismatch;
                take    = s_ready && bus.s_axis_tvalid;
                timeout = !take && (timer_q == 16'(TIMEOUT_CYCLES - 1));

                if (move_full) begin
                    out_valid_d = 1'b1;
                    out_data_d  = lanes_q;
                    out_keep_d  = '1;
                    out_last_d  = move_last;
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    lanes_d     = '0;
                    lane_cnt_d  = 4'd0;
                    lane_idx    = 3'd0;
                end
                if (take) begin
                    lanes_d[{lane_idx, 5'b0} +: 32] = bus.s_axis_tdata;
                    lane_cnt_d = lane_cnt_d + 4'd1;
                end

                timer_d = take ? 16'd0 : timer_q + 16'd1;

                if (move_last) begin
                    state_d = IDLE;
                    timer_d = 16'd0;
                end else if ((take && bus.s_axis_tlast) || mismatch || timeout) begin
                    state_d = FLUSH;
                    timer_d = 16'd0;
                end
            end

            FLUSH: begin
                // Closing beat; with no pending lanes it is an empty tlast marker.
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = lanes_q;
                    out_keep_d  = lane_keep(lane_cnt_q);
                    out_last_d  = 1'b1;
                    lanes_d     = '0;
                    lane_cnt_d  = 4'd0;
                    beat_cnt_d  = 8'd0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            roll_q      <= '0;
            lanes_q     <= '0;
            lane_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            timer_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            roll_q      <= roll_d;
            lanes_q     <= lanes_d;
            lane_cnt_q  <= lane_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            timer_q     <= timer_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.s_axis_tready = s_ready && !rst;
    assign bus.m_axis_tvalid = out_valid_q;
    assign bus.m_axis_tdata  = out_data_q;
    assign bus.m_axis_tkeep  = out_keep_q;
    assign bus.m_axis_tlast  = out_last_q;

`ifdef SI_PACKETIZER_STATS_EN
    logic [31:0] packet_count_q, packet_count_d;
    logic [31:0] tag_count_q, tag_count_d;

    // Packet and tag counters, free-running with wrap
    always_comb begin
        packet_count_d = packet_count_q;
        tag_count_d    = tag_count_q;
        if (out_valid_q && bus.m_axis_tready && out_last_q) packet_count_d = packet_count_q + 32'd1;
        if (take) tag_count_d = tag_count_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            packet_count_q <= '0;
            tag_count_q    <= '0;
        end else begin
            packet_count_q <= packet_count_d;
            tag_count_q    <= tag_count_d;
        end
    end

    assign packet_count = packet_count_q;
    assign tag_count    = tag_count_q;
`endif

endmodule

// File: tb/tb_si_tag_packetizer.sv
// Directed testbench for si_tag_packetizer.
// Inputs change 1 ns after the falling edge; a monitor records handshakes
// 1 ns before each rising edge.
module tb_si_tag_packetizer;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    si_tag_packetizer_if bus ();

`ifdef SI_PACKETIZER_STATS_EN
    logic [31:0] packet_count;
    logic [31:0] tag_count;
`endif

    si_tag_packetizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SI_PACKETIZER_STATS_EN
        ,
        .packet_count (packet_count),
        .tag_count    (tag_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Recorded output beats and input acceptances
    logic [255:0] q_data[$];
    logic [31:0]  q_keep[$];
    logic         q_last[$];
    int           acc_cyc[$];

    always @(negedge clk) begin
        #4;
        if (!rst) begin
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                q_data.push_back(bus.m_axis_tdata);
                q_keep.push_back(bus.m_axis_tkeep);
                q_last.push_back(bus.m_axis_tlast);
            end
            if (bus.s_axis_tvalid && bus.s_axis_tready) acc_cyc.push_back(cyc_cnt);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] hdr(input logic [31:0] seq, input logic [31:0] roll);
        logic [255:0] h;
        h = '0;
        h[31:0]  = seq;
        h[63:32] = roll;
        h[79:64] = 16'h5349;
        h[87:80] = 8'h01;
        return h;
    endfunction

    function automatic logic [255:0] beat(input logic [31:0] first, input int n);
        logic [255:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[32*i +: 32] = first + 32'(i);
        return b;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] d, input logic [31:0] u, input logic l);
        step();
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tuser  = u;
        bus.s_axis_tlast  = l;
    endtask

    task automatic complete(input string tag);
        int n;
        n = 0;
        #1;
        while (!bus.s_axis_tready && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 3000) begin
            errors++;
            $error("FAIL %s: tready wait expired, observed %0d cycles required < 3000", tag, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] u, input logic l);
        present(d, u, l);
        complete("send");
    endtask

    task automatic drop();
        step();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int want, input int limit);
        int n;
        n = 0;
        while (q_data.size() < want && n < limit) begin
            step();
            n++;
        end
        chk(tag, 256'(q_data.size()), 256'(want));
    endtask

    initial begin
        int base;
        int tbase;

        rst               = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tuser  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_s_tready", bus.s_axis_tready, 1'b0);
        chk("rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("rst_m_tdata",  bus.m_axis_tdata,  '0);
        chk("rst_m_tkeep",  bus.m_axis_tkeep,  '0);
        chk("rst_m_tlast",  bus.m_axis_tlast,  1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_tready", bus.s_axis_tready, 1'b1);

        // 128 tags, tuser 5: header + 16 full beats, one tag per cycle
        base  = q_data.size();
        tbase = acc_cyc.size();
        for (int i = 0; i < 128; i++) send(32'(i), 32'd5, 1'b0);
        drop();
        wait_beats("full_pkt_count", base + 17, 200);
        chk("full_pkt_hdr",      q_data[base], hdr(32'd0, 32'd5));
        chk("full_pkt_hdr_keep", q_keep[base], 32'hFFFF_FFFF);
        chk("full_pkt_hdr_last", q_last[base], 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("full_pkt_beat", q_data[base+1+b], beat(32'(8*b), 8));
            chk("full_pkt_keep", q_keep[base+1+b], 32'hFFFF_FFFF);
            chk("full_pkt_last", q_last[base+1+b], (b == 15));
        end
        chk("full_pkt_lane7", q_data[base+16][255:224], 32'd127);
        chk("throughput", 256'(acc_cyc[tbase+127] - acc_cyc[tbase]), 256'd127);

        // 3 tags then idle: partial beat appears only after the timeout
        base = q_data.size();
        send(32'd200, 32'd9, 1'b0);
        send(32'd201, 32'd9, 1'b0);
        send(32'd202, 32'd9, 1'b0);
        drop();
        repeat (1000) step();
        chk("timeout_not_early", 256'(q_data.size()), 256'(base + 1));
        wait_beats("timeout_count", base + 2, 200);
        chk("timeout_hdr",  q_data[base],   hdr(32'd1, 32'd9));
        chk("timeout_data", q_data[base+1], beat(32'd200, 3));
        chk("timeout_keep", q_keep[base+1], 32'h0000_0FFF);
        chk("timeout_last", q_last[base+1], 1'b1);

        // 8 tags then idle: full beat without tlast, then an empty tlast beat
        base = q_data.size();
        for (int i = 0; i < 8; i++) send(32'(600 + i), 32'd4, 1'b0);
        drop();
        wait_beats("empty_close_count", base + 3, 1200);
        chk("empty_close_hdr",   q_data[base],   hdr(32'd2, 32'd4));
        chk("empty_close_beat",  q_data[base+1], beat(32'd600, 8));
        chk("empty_close_blast", q_last[base+1], 1'b0);
        chk("empty_close_zdata", q_data[base+2], '0);
        chk("empty_close_zkeep", q_keep[base+2], 32'h0);
        chk("empty_close_zlast", q_last[base+2], 1'b1);

        // Rollover change 7,7,8 after a fresh reset
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        base = q_data.size();
        send(32'd100, 32'd7, 1'b0);
        send(32'd101, 32'd7, 1'b0);
        send(32'd102, 32'd8, 1'b1);
        drop();
        wait_beats("roll_count", base + 4, 100);
        chk("roll_hdr_a",  q_data[base],   hdr(32'd0, 32'd7));
        chk("roll_data_a", q_data[base+1], beat(32'd100, 2));
        chk("roll_keep_a", q_keep[base+1], 32'h0000_00FF);
        chk("roll_last_a", q_last[base+1], 1'b1);
        chk("roll_hdr_b",  q_data[base+2], hdr(32'd1, 32'd8));
        chk("roll_data_b", q_data[base+3], beat(32'd102, 1));
        chk("roll_keep_b", q_keep[base+3], 32'h0000_000F);
        chk("roll_last_b", q_last[base+3], 1'b1);

        // Output backpressure for 20 cycles with lanes full
        base  = q_data.size();
        tbase = acc_cyc.size();
        step();
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'(300 + i), 32'd3, 1'b0);
        present(32'd308, 32'd3, 1'b0);
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("bp_s_tready", bus.s_axis_tready, 1'b0);
            chk("bp_m_tvalid", bus.m_axis_tvalid, 1'b1);
            chk("bp_m_tdata",  bus.m_axis_tdata,  hdr(32'd2, 32'd3));
            chk("bp_m_tlast",  bus.m_axis_tlast,  1'b0);
            step();
        end
        bus.m_axis_tready = 1'b1;
        complete("bp_resume");
        for (int i = 9; i < 16; i++) send(32'(300 + i), 32'd3, (i == 15));
        drop();
        wait_beats("bp_count", base + 3, 100);
        chk("bp_hdr",   q_data[base],   hdr(32'd2, 32'd3));
        chk("bp_beat0", q_data[base+1], beat(32'd300, 8));
        chk("bp_last0", q_last[base+1], 1'b0);
        chk("bp_beat1", q_data[base+2], beat(32'd308, 8));
        chk("bp_last1", q_last[base+2], 1'b1);
        chk("bp_tags",  256'(acc_cyc.size() - tbase), 256'd16);

        // Reset in the middle of a packet
        base = q_data.size();
        for (int i = 0; i < 5; i++) send(32'(400 + i), 32'd6, 1'b0);
        drop();
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        chk("midrst_s_tready", bus.s_axis_tready, 1'b0);
        chk("midrst_m_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("midrst_m_tdata",  bus.m_axis_tdata,  '0);
        chk("midrst_m_tkeep",  bus.m_axis_tkeep,  '0);
        chk("midrst_m_tlast",  bus.m_axis_tlast,  1'b0);
`ifdef SI_PACKETIZER_STATS_EN
        chk("midrst_packet_count", packet_count, 32'd0);
        chk("midrst_tag_count",    tag_count,    32'd0);
`endif
        chk("midrst_beats",    256'(q_data.size()), 256'(base + 1));
        chk("midrst_no_tlast", q_last[base], 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", bus.s_axis_tready, 1'b1);
        send(32'd500, 32'd6, 1'b1);
        drop();
        wait_beats("midrst_count", base + 3, 100);
        chk("midrst_hdr",  q_data[base+1], hdr(32'd0, 32'd6));
        chk("midrst_data", q_data[base+2], beat(32'd500, 1));
        chk("midrst_keep", q_keep[base+2], 32'h0000_000F);
        chk("midrst_last", q_last[base+2], 1'b1);
`ifdef SI_PACKETIZER_STATS_EN
        step();
        chk("stats_packet_count", packet_count, 32'd1);
        chk("stats_tag_count",    tag_count,    32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/si_tag_packetizer.md
SI_TAG_PACKETIZER -- requirements
Module: si_tag_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, 256: output beat width; only 256 is supported, and elaboration SHALL stop with $error otherwise.
REQ-002 Parameter KEEP_WIDTH, (DATA_WIDTH+7)/8: output byte-enable width.
REQ-003 Parameter MAX_BEATS, 16: payload beats per packet, range 1..255.
REQ-004 Parameter TIMEOUT_CYCLES, 1024: idle cycles before a partial packet is flushed, range 1..65535.
REQ-005 clk  in  1: sole clock; one clock; reset is synchronous and active-high.
REQ-006 rst  in  1: synchronous, active-high reset.
REQ-007 s_axis_tvalid/tready  in/out  1/1: tag input handshake.
REQ-008 s_axis_tdata  in  32: one time tag.
REQ-009 s_axis_tlast  in  1: forces packet end after this tag.
REQ-010 s_axis_tuser  in  32: rollover time of this tag.
REQ-011 m_axis_tvalid/tready  out/in  1/1: packet output handshake.
REQ-012 m_axis_tdata  out  256: header or payload beat.
REQ-013 m_axis_tkeep  out  32: byte enables.
REQ-014 m_axis_tlast  out  1: last beat of packet.

Function
REQ-015 States SHALL be IDLE, FILL and FLUSH; packet framing SHALL be one header beat followed by 1..MAX_BEATS payload beats.
REQ-016 First tag accepted in IDLE SHALL load the header beat into the output register and put the tag in lane 0; state goes to FILL; header m_axis_tvalid rises the next cycle.
REQ-017 Header: [31:0]=sequence, [63:32]=packet rollover (tuser of first tag), [79:64]=16'h5349, [87:80]=8'h01, other bits 0, tkeep all ones, tlast 0.
REQ-018 Sequence SHALL start at 0, increment once per header, and wrap 0xFFFFFFFF->0.
REQ-019 Payload lanes: tag n of a beat in bits [32n+31:32n], filled lowest lane first.
REQ-020 When 8 lanes fill, the beat SHALL move to the output register as soon as it is empty or being consumed; otherwise s_axis_tready SHALL be 0.
REQ-021 The MAX_BEATS-th payload beat SHALL carry tlast=1; state goes to IDLE.
REQ-022 Partial beat with n tags: tkeep low 4n bits set, unused lanes zero, tlast=1.
REQ-023 A partial beat SHALL be flushed in these cases: s_axis_tlast is accepted; TIMEOUT_CYCLES consecutive FILL cycles pass with no accepted tag; or a valid tag's tuser differs from the packet rollover.
REQ-024 On a tuser mismatch, s_axis_tready SHALL be 0 until the flush completes, and that tag SHALL then start a new packet.
REQ-025 If the flush leaves zero pending lanes, the last emitted payload beat is already sent; the timeout case SHALL then emit an all-zero beat with tkeep=0 and tlast=1, so every packet ends with tlast.
REQ-026 A tag accepted in the cycle the timeout would expire SHALL be kept, and the timer SHALL restart.
REQ-027 m_axis_tdata/tkeep/tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-028 Throughput: with m_axis_tready=1 continuously, one tag SHALL be accepted per cycle except during the header-load cycle.

Reset
REQ-029 On rst: state=IDLE, sequence=0, timer=0, lanes cleared, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, s_axis_tready=0.
REQ-030 s_axis_tready SHALL be 1 on the first cycle after rst deasserts.
REQ-031 Reset mid-packet SHALL discard the partial packet without emitting tlast.

Configuration
REQ-032 Macro SI_PACKETIZER_STATS_EN:
- Defined: adds outputs packet_count[31:0] (increments on each accepted beat with tlast=1) and tag_count[31:0] (increments on each accepted input tag); both reset to 0 and wrap.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Verification
REQ-033 Feed 128 tags 0..127 with tuser=5 and tready=1 -> header seq=0, rollover=5; 16 payload beats; beat 15 has tlast=1 and lane 7=127.
REQ-034 Feed 3 tags, then idle 1024 cycles -> one payload beat with tkeep=0x00000FFF and tlast=1, lanes 3..7 zero.
REQ-035 Tags with tuser 7,7,8 -> packet A (2 tags, tlast), then packet B header with rollover=8 and seq=1.
REQ-036 Hold m_axis_tready=0 for 20 cycles mid-packet -> output stable, s_axis_tready low once lanes are full, no tag lost or duplicated.
REQ-037 Assert rst after 5 tags of a packet -> outputs at reset values, next packet header seq=0; with SI_PACKETIZER_STATS_EN defined, packet_count=0.
